// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register bank write port: round-robin between ALU (src0)
// and LSU (src1), registered bank write, and a busy-bit scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
  parameter int N    = 32,
  parameter int Bits = 64,
  localparam int PW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s0_valid,
  input  logic [PW-1:0]   s0_ptr,
  input  logic [Bits-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [PW-1:0]   s1_ptr,
  input  logic [Bits-1:0] s1_data,
  output logic            s1_ready,
  input  logic            iss_valid,
  input  logic [PW-1:0]   iss_ptr,
  input  logic [PW-1:0]   chk_ptr_1,
  input  logic [PW-1:0]   chk_ptr_2,
  output logic            hazard,
  output logic [PW-1:0]   ptr_wr,
  output logic [Bits-1:0] data_wr,
  output logic            wr_en,
  output logic [N-1:0]    busy
);

  logic            last_grant_q, last_grant_d;
  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   ptr_wr_q, ptr_wr_d;
  logic [Bits-1:0] data_wr_q, data_wr_d;
  logic [N-1:0]    busy_q, busy_d;
  logic            gnt0, gnt1;

  // On contention the source that did not win last time gets the port.
  always_comb begin
    gnt0 = s0_valid & (~s1_valid | last_grant_q);
    gnt1 = s1_valid & (~s0_valid | ~last_grant_q);
  end

  assign s0_ready = gnt0 & ~rst;
  assign s1_ready = gnt1 & ~rst;

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    ptr_wr_d     = ptr_wr_q;
    data_wr_d    = data_wr_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      wr_en_d      = (s0_ptr != '0);
      ptr_wr_d     = s0_ptr;
      data_wr_d    = s0_data;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      wr_en_d      = (s1_ptr != '0);
      ptr_wr_d     = s1_ptr;
      data_wr_d    = s1_data;
    end
  end

  // Clear from the registered write first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q)
      busy_d[ptr_wr_q] = 1'b0;
    if (iss_valid && iss_ptr != '0)
      busy_d[iss_ptr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      ptr_wr_q     <= '0;
      data_wr_q    <= '0;
      busy_q       <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      ptr_wr_q     <= ptr_wr_d;
      data_wr_q    <= data_wr_d;
      busy_q       <= busy_d;
    end
  end

  assign hazard  = busy_q[chk_ptr_1] | busy_q[chk_ptr_2];
  assign wr_en   = wr_en_q;
  assign ptr_wr  = ptr_wr_q;
  assign data_wr = data_wr_q;
  assign busy    = busy_q;

endmodule
